// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential halfword fetches to the icache,
// buffers hits in a small flop FIFO and hands them to decode with their PCs.
module fetch_queue #(
  parameter int VA       = 16,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect,
  input  logic [VA-2:0]                redirect_pc,
  output logic [VA-2:0]                fetch_pc,
  output logic                         fetch_req,
  input  logic                         fetch_hit,
  input  logic [15:0]                  fetch_ins,
  output logic [15:0]                  ins,
  output logic [VA-2:0]                ins_pc,
  output logic                         iready,
  input  logic                         take,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [VA-1:0] RST_ADDR = VA'(RESET_PC);
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);

  logic [DEPTH-1:0][15:0]   q_ins;
  logic [DEPTH-1:0][VA-2:0] q_pc;
  logic [PW-1:0]            rd_ptr, wr_ptr, rd_nxt;
  logic [LW-1:0]            level_nxt;
  logic [15:0]              head_ins;
  logic [VA-2:0]            head_pc;
  logic                     enq, deq;

  // Gated on registered level only, so take never reaches the icache request.
  assign fetch_req = !reset && !redirect && (level != FULL);
  assign enq       = fetch_req && fetch_hit;
  assign deq       = take && iready;

  always_comb begin
    rd_nxt    = rd_ptr + PW'(deq);
    level_nxt = level + LW'(enq) - LW'(deq);
    head_ins  = q_ins[rd_nxt];
    head_pc   = q_pc[rd_nxt];
    // New head may be the entry landing this very cycle.
    if (enq && (wr_ptr == rd_nxt)) begin
      head_ins = fetch_ins;
      head_pc  = fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_ins[wr_ptr] <= fetch_ins;
      q_pc[wr_ptr]  <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RST_ADDR[VA-1:1];
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      iready   <= 1'b0;
      ins      <= '0;
      ins_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      iready   <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + (VA-1)'(1);
      end
      rd_ptr <= rd_nxt;
      level  <= level_nxt;
      iready <= (level_nxt != '0);
      // Output registers hold the last instruction once the queue runs dry.
      if (level_nxt != '0) begin
        ins    <= head_ins;
        ins_pc <= head_pc;
      end
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between the instruction cache and the decoder.
- Generates sequential halfword fetch addresses towards icache and captures 16-bit instructions on cache hits.
- Presents instructions in order, each with its PC, to the decode stage through a valid/take handshake.
- Flushes and restarts on any control-flow redirect (jump, branch taken, trap, syscall) from execute.

Parameters:
VA, 16, virtual address width; PCs are halfword addresses [VA-1:1]
DEPTH, 2, queue entries; power of two, >=2
RESET_PC, 0, byte address of first fetch after reset (bit 0 ignored)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect  in  1  flush queue, restart fetch at redirect_pc
redirect_pc  in  VA-1  new fetch halfword address [VA-1:1]
fetch_pc  out  VA-1  halfword address presented to icache
fetch_req  out  1  fetch requested this cycle
fetch_hit  in  1  icache hit; fetch_ins valid for fetch_pc this cycle
fetch_ins  in  16  instruction from icache
ins  out  16  head instruction to decode
ins_pc  out  VA-1  PC of head instruction
iready  out  1  head entry valid
take  in  1  decode consumes head this cycle
level  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Only clk is used as a clock. reset is sampled on the rising edge and has priority over everything.
- Reset values:
  - fetch_pc=RESET_PC[VA-1:1].
  - level=0, iready=0, ins=0, ins_pc=0.
  - Read/write pointers=0.
  - fetch_req=0 while reset is high (combinational gating).
- fetch_req = !reset && !redirect && (level != DEPTH). It depends on the registered level only; no combinational path from take.
- Enqueue condition: fetch_req && fetch_hit.
  - fetch_ins and fetch_pc are written at the tail; tail pointer increments.
  - fetch_pc <= fetch_pc+1, modulo 2^(VA-1), so 0x7FFF wraps to 0x0000 for VA=16.
- Miss (fetch_req && !fetch_hit): fetch_pc holds and nothing is written. The icache handles the line fill.
- Full with take in the same cycle: no enqueue that cycle, even if fetch_hit. The entry freed by take is fillable from the next cycle.
- Dequeue condition: take && iready. Head pointer increments. take while !iready is ignored.
- Simultaneous enqueue and dequeue: level unchanged, both pointers advance.
- Outputs:
  - ins/ins_pc/iready reflect the registered head entry.
  - Latency from an accepted hit at cycle N to iready=1 at N+1. No same-cycle bypass.
  - When empty, ins/ins_pc hold their last value with iready=0.
- Redirect (not in reset):
  - Next cycle: level=0, pointers=0, iready=0, fetch_pc=redirect_pc.
  - A hit or take in the redirect cycle is discarded.
  - fetch_req=0 during the redirect cycle.
- Back-to-back redirects: the last one wins. No fetch is issued between them.
- Reset mid-stream: all entries discarded; restart at RESET_PC.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level saturates by construction (never enqueues at DEPTH, never dequeues at 0).
- Storage is DEPTH x (16+VA-1) flops. No RAM.

Test Plan:
1. Reset, RESET_PC=0x0100:
   - During reset: fetch_req=0, fetch_pc=0x080, iready=0, level=0.
   - First cycle after release: fetch_req=1.
2. Streaming, fetch_hit=1 every cycle, fetch_ins=0x4501+n, take=1:
   - iready=1 from the second post-reset cycle.
   - ins sequence 0x4501,0x4502,...; ins_pc 0x080,0x081,...
   - level stays at 1.
3. Fill with take=0 and hits:
   - After 2 enqueues: level=2, fetch_req=0, fetch_pc=0x082. A further hit is ignored.
   - Pulse take: ins advances to the second entry, level=1, fetch_req=1 the next cycle.
4. Redirect while full, with fetch_hit=1 and take=1 in the same cycle, redirect_pc=0x1234:
   - Next cycle: iready=0, level=0, fetch_pc=0x1234.
   - The first subsequent hit appears with ins_pc=0x1234.
5. Miss stall, fetch_hit=0 for 5 cycles with take=1:
   - fetch_pc constant.
   - Queue drains: iready falls after the last entry is taken.
   - Fetch resumes on the next hit with the correct ins_pc.
6. Wrap and reset:
   - redirect_pc=0x7FFF then a hit: ins_pc=0x7FFF, fetch_pc=0x0000.
   - Assert reset with level=2: next cycle level=0, fetch_pc=0x080.
